bitrev_ctrl: RTL

SPI master controller that sequences a single bit-reverse SPI slave peripheral. It accepts one byte per request on a valid/ready port and clocks the byte out MSB-first over SPI mode 0 (8 sck pulses). It then clocks 8 more pulses to collect the slave's reply and returns the reassembled byte (bit-reverse of the request) on a valid/ready response port. It sits between a bus-side requester (CPU bridge or test driver) and the slave's `sck`/`ss`/`mosi`/`miso` pins.

---
 rtl/bitrev_ctrl_pkg.sv | 31 +++
 rtl/bitrev_sck_gen.sv | 58 +++++
 rtl/bitrev_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bitrev_ctrl_pkg.sv
// ============================================================================
// Module   : bitrev_ctrl_pkg
// Brief    : Shared state type, byte width and bit-reverse helper for bitrev_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitrev_ctrl_pkg;

    localparam int BITREV_CTRL_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_TX = 2'd1,
        ST_SHIFT_RX = 2'd2,
        ST_RESP     = 2'd3
    } bitrev_ctrl_state_t;

    function automatic logic [BITREV_CTRL_BITS-1:0] bitrev(
        input logic [BITREV_CTRL_BITS-1:0] d
    );
        logic [BITREV_CTRL_BITS-1:0] r;
        for (int i = 0; i < BITREV_CTRL_BITS; i++) begin
            r[i] = d[BITREV_CTRL_BITS-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitrev_sck_gen.sv
// ============================================================================
// Module   : bitrev_sck_gen
// Brief    : SPI mode-0 clock divider; sck plus strobes marking the edge where sck toggles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitrev_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;
    logic       tick;

    assign tick = en && (div_q == DIV_LAST);

    // Strobes are high in the cycle whose closing edge toggles sck.
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    assign sck  = sck_q;

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (!en) begin
            div_d = 8'd0;
            sck_d = 1'b0;
        end else if (tick) begin
            div_d = 8'd0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bitrev_ctrl.sv
// ============================================================================
// Module   : bitrev_ctrl
// Brief    : SPI master sending one byte and reading back its bit-reversed echo.
//            Optional reply checker enabled by macro BITREV_CTRL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitrev_ctrl
    import bitrev_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [BITREV_CTRL_BITS-1:0] req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [BITREV_CTRL_BITS-1:0] rsp_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        sck,
    output logic                        ss,
    output logic                        mosi,
    input  logic                        miso
);

    bitrev_ctrl_state_t          state_q, state_d;
    logic [BITREV_CTRL_BITS-1:0] tx_q, tx_d;
    logic [BITREV_CTRL_BITS-1:0] rx_q, rx_d;
    logic [BITREV_CTRL_BITS-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]                  bit_cnt_q, bit_cnt_d;
    logic                        mosi_q, mosi_d;
    logic                        ss_q, ss_d;
    logic                        sck_en, sck_rise, sck_fall;
    logic                        req_fire, last_bit, rsp_load;

    assign sck_en    = (state_q == ST_SHIFT_TX) || (state_q == ST_SHIFT_RX);
    assign req_fire  = (state_q == ST_IDLE) && req_valid;
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign rsp_load  = (state_q == ST_SHIFT_RX) && sck_fall && last_bit;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign ss        = ss_q;
    assign mosi      = mosi_q;

    bitrev_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clock  (clock),
        .resetn (resetn),
        .en     (sck_en),
        .sck    (sck),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rsp_data_d = rsp_data_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    tx_d      = req_data;
                    mosi_d    = req_data[BITREV_CTRL_BITS-1];
                    ss_d      = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SHIFT_TX;
                end
            end
            ST_SHIFT_TX: begin
                if (sck_fall) begin
                    // Counter wraps 7->0 here, ready for the receive phase.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        mosi_d  = 1'b0;
                        state_d = ST_SHIFT_RX;
                    end else begin
                        tx_d   = {tx_q[BITREV_CTRL_BITS-2:0], 1'b0};
                        mosi_d = tx_q[BITREV_CTRL_BITS-2];
                    end
                end
            end
            ST_SHIFT_RX: begin
                if (sck_rise) begin
                    rx_d = {rx_q[BITREV_CTRL_BITS-2:0], miso};
                end
                if (sck_fall) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                if (rsp_load) begin
                    ss_d       = 1'b1;
                    rsp_data_d = rx_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            rsp_data_q <= '0;
            bit_cnt_q  <= 3'd0;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rsp_data_q <= rsp_data_d;
            bit_cnt_q  <= bit_cnt_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
        end
    end

`ifdef BITREV_CTRL_CHECK_EN
    // tx_q is consumed by shifting, so the request byte is kept separately.
    logic [BITREV_CTRL_BITS-1:0] sent_q, sent_d;
    logic                        rsp_err_q, rsp_err_d;

    always_comb begin
        sent_d    = sent_q;
        rsp_err_d = rsp_err_q;
        if (req_fire) begin
            sent_d = req_data;
        end
        if (rsp_load) begin
            rsp_err_d = (rx_q != bitrev(sent_q));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sent_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            sent_q    <= sent_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire
